// File: rtl/i2s_rx_arbiter.sv
// i2s_rx_arbiter: collects completed samples from N_CHANNELS i2sin receivers
// and forwards them one at a time over a valid/ready port, round-robin fair.
// Optional feature: define I2S_RX_ARBITER_DROP_CNT_EN to add a saturating
// drop_count of overrun events plus its clr_drop_count clear input.
// All state updates on the falling edge of sck.

module i2s_rx_arbiter #(
    parameter int unsigned N_CHANNELS     = 4,
    parameter int unsigned BITS_PRECISION = 24,
    localparam int unsigned CH_W          = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
    input  logic                               sck,
    input  logic                               rst,
    input  logic [N_CHANNELS*BITS_PRECISION-1:0] ch_data,
    input  logic [N_CHANNELS-1:0]              ch_lrn,
    input  logic [N_CHANNELS-1:0]              ch_en,
    output logic [BITS_PRECISION-1:0]          out_data,
    output logic                               out_lrn,
    output logic [CH_W-1:0]                    out_ch,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [N_CHANNELS-1:0]              overrun,
    input  logic [N_CHANNELS-1:0]              clr_overrun
`ifdef I2S_RX_ARBITER_DROP_CNT_EN
    ,
    output logic [15:0]                        drop_count,
    input  logic                               clr_drop_count
`endif
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e                    state_q, state_d;
    logic [BITS_PRECISION-1:0] slot_data_q [N_CHANNELS];
    logic [BITS_PRECISION-1:0] slot_data_d [N_CHANNELS];
    logic [N_CHANNELS-1:0]     slot_lrn_q, slot_lrn_d;
    logic [N_CHANNELS-1:0]     pending_q, pending_d;
    logic [CH_W-1:0]           rr_q, rr_d;
    logic [BITS_PRECISION-1:0] out_data_q, out_data_d;
    logic                      out_lrn_q, out_lrn_d;
    logic [CH_W-1:0]           out_ch_q, out_ch_d;
    logic [N_CHANNELS-1:0]     overrun_q, overrun_d;

    logic                      do_grant;
    logic                      grant_found;
    logic [CH_W-1:0]           grant_idx;
    logic [N_CHANNELS-1:0]     grant_oh;
    logic [N_CHANNELS-1:0]     ovr_evt;

    // A new grant is taken when the output is empty or being consumed this edge
    assign do_grant = (state_q == StEmpty) || out_ready;

    // Round-robin scan of pending slots starting at rr
    always_comb begin
        logic [CH_W-1:0] idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_oh    = '0;
        idx         = '0;
        for (int unsigned k = 0; k < N_CHANNELS; k++) begin
            idx = CH_W'((32'(rr_q) + k) % N_CHANNELS);
            if (!grant_found && pending_q[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
        if (do_grant && grant_found) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    // Overrun: capture into a pending slot that is not being drained this edge
    assign ovr_evt = ch_en & pending_q & ~grant_oh;

    // Next-state for output FSM, slots, round-robin pointer and overrun flags
    always_comb begin
        state_d    = state_q;
        slot_data_d = slot_data_q;
        slot_lrn_d = slot_lrn_q;
        pending_d  = pending_q;
        rr_d       = rr_q;
        out_data_d = out_data_q;
        out_lrn_d  = out_lrn_q;
        out_ch_d   = out_ch_q;

        if (do_grant && grant_found) begin
            state_d              = StFull;
            out_data_d           = slot_data_q[grant_idx];
            out_lrn_d            = slot_lrn_q[grant_idx];
            out_ch_d             = grant_idx;
            pending_d[grant_idx] = 1'b0;
            rr_d                 = CH_W'((32'(grant_idx) + 1) % N_CHANNELS);
        end else if (do_grant) begin
            state_d = StEmpty;
        end

        // Capture after grant so a same-edge grant takes the old contents
        for (int unsigned i = 0; i < N_CHANNELS; i++) begin
            if (ch_en[i]) begin
                slot_data_d[i] = ch_data[i*BITS_PRECISION +: BITS_PRECISION];
                slot_lrn_d[i]  = ch_lrn[i];
                pending_d[i]   = 1'b1;
            end
        end

        // Set wins over clear
        overrun_d = (overrun_q & ~clr_overrun) | ovr_evt;
    end

    // State registers
    always_ff @(negedge sck or posedge rst) begin
        if (rst) begin
            state_q    <= StEmpty;
            slot_lrn_q <= '0;
            pending_q  <= '0;
            rr_q       <= '0;
            out_data_q <= '0;
            out_lrn_q  <= 1'b0;
            out_ch_q   <= '0;
            overrun_q  <= '0;
            for (int unsigned i = 0; i < N_CHANNELS; i++) begin
                slot_data_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            slot_data_q <= slot_data_d;
            slot_lrn_q  <= slot_lrn_d;
            pending_q   <= pending_d;
            rr_q        <= rr_d;
            out_data_q  <= out_data_d;
            out_lrn_q   <= out_lrn_d;
            out_ch_q    <= out_ch_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_valid = (state_q == StFull);
    assign out_data  = out_data_q;
    assign out_lrn   = out_lrn_q;
    assign out_ch    = out_ch_q;
    assign overrun   = overrun_q;

`ifdef I2S_RX_ARBITER_DROP_CNT_EN
    logic [15:0] drop_q, drop_d;
    logic [4:0]  n_evt;
    logic [16:0] drop_sum;

    // Saturating count of overrun events; several channels may overrun at once
    always_comb begin
        n_evt = '0;
        for (int unsigned i = 0; i < N_CHANNELS; i++) begin
            n_evt = n_evt + 5'(ovr_evt[i]);
        end
        drop_sum = {1'b0, drop_q} + 17'(n_evt);
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        if (clr_drop_count) begin
            drop_d = '0;
        end
    end

    // Drop counter register
    always_ff @(negedge sck or posedge rst) begin
        if (rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_i2s_rx_arbiter.sv
// Self-checking bench for i2s_rx_arbiter (N_CHANNELS=4, BITS_PRECISION=24).
// Directed scenarios followed by random traffic, all checked against a
// behavioural model of the arbiter kept in the bench.

module tb_i2s_rx_arbiter;

    localparam int N = 4;
    localparam int W = 24;

    logic           sck = 1'b0;
    logic           rst;
    logic [N*W-1:0] ch_data;
    logic [N-1:0]   ch_lrn;
    logic [N-1:0]   ch_en;
    logic [W-1:0]   out_data;
    logic           out_lrn;
    logic [1:0]     out_ch;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   overrun;
    logic [N-1:0]   clr_overrun;
`ifdef I2S_RX_ARBITER_DROP_CNT_EN
    logic [15:0]    drop_count;
    logic           clr_drop_count;
`endif

    i2s_rx_arbiter #(
        .N_CHANNELS    (N),
        .BITS_PRECISION(W)
    ) dut (
        .sck        (sck),
        .rst        (rst),
        .ch_data    (ch_data),
        .ch_lrn     (ch_lrn),
        .ch_en      (ch_en),
        .out_data   (out_data),
        .out_lrn    (out_lrn),
        .out_ch     (out_ch),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun),
        .clr_overrun(clr_overrun)
`ifdef I2S_RX_ARBITER_DROP_CNT_EN
        ,
        .drop_count    (drop_count),
        .clr_drop_count(clr_drop_count)
`endif
    );

    always #5 sck = ~sck;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [W-1:0] m_slot [N];
    bit   [N-1:0] m_slot_lrn;
    bit   [N-1:0] m_pend;
    int           m_rr;
    bit           m_valid;
    logic [W-1:0] m_data;
    bit           m_lrn;
    int           m_ch;
    bit   [N-1:0] m_ovr;
    int           m_drop;

    int           acc_ch [$];
    int           acc_data [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_slot[i] = '0;
        m_slot_lrn = '0;
        m_pend     = '0;
        m_rr       = 0;
        m_valid    = 0;
        m_data     = '0;
        m_lrn      = 0;
        m_ch       = 0;
        m_ovr      = '0;
        m_drop     = 0;
    endtask

    // One falling edge of the arbiter, evaluated from the rules directly
    task automatic model_update();
        bit [N-1:0] old_pend;
        bit [N-1:0] ev_mask;
        int         g;
        int         ev;
        bit         take;
        old_pend = m_pend;
        ev_mask  = '0;
        g        = -1;
        ev       = 0;
        take     = !m_valid || out_ready;
        if (take) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
            end
            if (g >= 0) begin
                m_valid   = 1;
                m_data    = m_slot[g];
                m_lrn     = m_slot_lrn[g];
                m_ch      = g;
                m_pend[g] = 0;
                m_rr      = (g + 1) % N;
            end else begin
                m_valid = 0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (ch_en[i]) begin
                if (old_pend[i] && i != g) begin
                    ev_mask[i] = 1;
                    ev++;
                end
                m_slot[i]     = ch_data[i*W +: W];
                m_slot_lrn[i] = ch_lrn[i];
                m_pend[i]     = 1;
            end
        end
        m_ovr = (m_ovr & ~clr_overrun) | ev_mask;
`ifdef I2S_RX_ARBITER_DROP_CNT_EN
        if (clr_drop_count) m_drop = 0;
        else m_drop = (m_drop + ev > 65535) ? 65535 : m_drop + ev;
`endif
    endtask

    task automatic compare();
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            check("out_data", 32'(out_data), 32'(m_data));
            check("out_lrn", 32'(out_lrn), 32'(m_lrn));
            check("out_ch", 32'(out_ch), 32'(m_ch));
        end
        check("overrun", 32'(overrun), 32'(m_ovr));
`ifdef I2S_RX_ARBITER_DROP_CNT_EN
        check("drop_count", 32'(drop_count), 32'(m_drop));
`endif
    endtask

    // Inputs are driven around the rising edge; the DUT acts on the falling edge
    task automatic step();
        if (out_valid && out_ready) begin
            acc_ch.push_back(int'(out_ch));
            acc_data.push_back(int'(out_data));
        end
        @(negedge sck);
        model_update();
        @(posedge sck);
        compare();
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_data"}, 32'(out_data), 32'd0);
        check({tag, "_lrn"}, 32'(out_lrn), 32'd0);
        check({tag, "_ch"}, 32'(out_ch), 32'd0);
        check({tag, "_ovr"}, 32'(overrun), 32'd0);
`ifdef I2S_RX_ARBITER_DROP_CNT_EN
        check({tag, "_drop"}, 32'(drop_count), 32'd0);
`endif
        rst = 1'b0;
    endtask

    task automatic set_ch(input int ch, input logic [W-1:0] d, input bit lrn);
        ch_data[ch*W +: W] = d;
        ch_lrn[ch]         = lrn;
    endtask

    initial begin
        rst         = 1'b1;
        ch_data     = '0;
        ch_lrn      = '0;
        ch_en       = '0;
        out_ready   = 1'b0;
        clr_overrun = '0;
`ifdef I2S_RX_ARBITER_DROP_CNT_EN
        clr_drop_count = 1'b0;
`endif
        model_reset();
        @(posedge sck);
        pulse_reset("reset");

        // Single sample on channel 2
        set_ch(2, 24'hABCDEF, 1'b1);
        ch_en = 4'b0100; out_ready = 1'b1;
        step();
        ch_en = '0;
        step();
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_data", 32'(out_data), 32'hABCDEF);
        check("single_ch", 32'(out_ch), 32'd2);
        check("single_lrn", 32'(out_lrn), 32'd1);
        step();
        check("single_done", 32'(out_valid), 32'd0);

        // All four channels at once, stalls in between
        pulse_reset("reset_b");
        for (int i = 0; i < N; i++) set_ch(i, W'(i + 1), i[0]);
        ch_en = 4'b1111; out_ready = 1'b0;
        step();
        ch_en = '0;
        acc_ch.delete();
        acc_data.delete();
        for (int c = 0; c < 10; c++) begin
            out_ready = c[0];
            step();
        end
        check("simul_count", 32'(acc_ch.size()), 32'd4);
        for (int i = 0; i < acc_ch.size() && i < N; i++) begin
            check("simul_order", 32'(acc_ch[i]), 32'(i));
            check("simul_data", 32'(acc_data[i]), 32'(i + 1));
        end

        // Round-robin: after channel 1, channel 3 wins over channel 0
        pulse_reset("reset_c");
        out_ready = 1'b0;
        set_ch(1, 24'h000101, 1'b0);
        ch_en = 4'b0010;
        step();
        ch_en = '0;
        step();
        check("rr_first", 32'(out_ch), 32'd1);
        set_ch(0, 24'h000100, 1'b1);
        set_ch(3, 24'h000103, 1'b0);
        ch_en = 4'b1001;
        step();
        ch_en = '0; out_ready = 1'b1;
        step();
        check("rr_second", 32'(out_ch), 32'd3);
        step();
        check("rr_third", 32'(out_ch), 32'd0);
        step();
        check("rr_empty", 32'(out_valid), 32'd0);

        // Overrun on channel 1, then clear and set-wins
        out_ready = 1'b0;
        set_ch(0, 24'h000007, 1'b0);
        ch_en = 4'b0001;
        step();
        ch_en = '0;
        step();
        set_ch(1, 24'h000011, 1'b1);
        ch_en = 4'b0010;
        step();
        set_ch(1, 24'h000022, 1'b1);
        step();
        check("ovr_set", 32'(overrun[1]), 32'd1);
        ch_en = '0; out_ready = 1'b1;
        step();
        check("ovr_data", 32'(out_data), 32'h000022);
        out_ready = 1'b0;
        set_ch(1, 24'h000033, 1'b0);
        ch_en = 4'b0010;
        step();
        ch_en = '0; clr_overrun = 4'b0010;
        step();
        check("ovr_clr", 32'(overrun[1]), 32'd0);
        set_ch(1, 24'h000044, 1'b0);
        ch_en = 4'b0010;
        step();
        check("ovr_setwins", 32'(overrun[1]), 32'd1);
        ch_en = '0; clr_overrun = '0; out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;

        // Same-slot grant and capture
        pulse_reset("reset_e");
        set_ch(1, 24'h000009, 1'b0);
        ch_en = 4'b0010;
        step();
        ch_en = '0;
        step();
        set_ch(0, 24'h000004, 1'b0);
        ch_en = 4'b0001;
        step();
        set_ch(0, 24'h000005, 1'b1);
        out_ready = 1'b1;
        step();
        check("same_old", 32'(out_data), 32'h000004);
        check("same_ovr", 32'(overrun), 32'd0);
        ch_en = '0;
        step();
        check("same_new", 32'(out_data), 32'h000005);
        check("same_ovr2", 32'(overrun), 32'd0);
        out_ready = 1'b0;

        // Reset in the middle of a transfer
        for (int i = 0; i < N; i++) set_ch(i, W'(32'h10 + i), 1'b0);
        ch_en = 4'b1111;
        step();
        ch_en = '0;
        step();
        check("mid_valid", 32'(out_valid), 32'd1);
        pulse_reset("mid_reset");
        step();
        check("mid_discard", 32'(out_valid), 32'd0);

        // Two simultaneous overruns
        ch_en = 4'b1111;
        step();
        ch_en = '0;
        step();
        ch_en = 4'b0110;
        step();
        check("dual_ovr", 32'(overrun), 32'b0110);
`ifdef I2S_RX_ARBITER_DROP_CNT_EN
        check("drop_two", 32'(drop_count), 32'd2);
        ch_en = 4'b0110; clr_drop_count = 1'b1;
        step();
        check("drop_clr", 32'(drop_count), 32'd0);
        clr_drop_count = 1'b0;
`endif
        ch_en = '0;

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) set_ch(i, W'($urandom), 1'($urandom));
            ch_en       = N'($urandom & $urandom);
            out_ready   = 1'($urandom_range(0, 1));
            clr_overrun = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
`ifdef I2S_RX_ARBITER_DROP_CNT_EN
            clr_drop_count = ($urandom_range(0, 31) == 0);
`endif
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
